inv_shift_rows_pipe: RTL
========================

Name: inv_shift_rows_pipe

Overview:
- Pipelined AES InvShiftRows stage for the decryption datapath. It is the inverse of the forward ShiftRows used by the encryptor.
- Accepts a 128-bit state over a valid/ready handshake and applies the inverse row rotation. Carries the result through STAGES register stages with full backpressure.
- Sits between the inverse-round AddRoundKey/InvMixColumns output and InvSubBytes in the decryptor round loop.

Parameters:
- STAGES, 2, number of register stages (legal 1..4); latency in cycles from accept to out_valid.
- CNT_W, 16, width of completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  block can accept state this cycle
- state_isr_in  input  128  state in; byte k = bits [8k+7:8k]; byte 15 is AES s(0,0), column-major
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- state_isr_out  output  128  InvShiftRows(state_isr_in)
- busy  output  1  any stage holds valid data
- xfer_cnt  output  CNT_W  count of output transfers
- err  output  1  sticky self-check error (see Optional Feature)

Behaviour:
- Clocking: single clock domain; rst_n is asynchronous assert, synchronous deassert, active-low.
- Byte mapping, combinational, applied at stage-0 input: out byte j = in byte src(j).
  - src for j = 0..15: 12, 9, 6, 3, 0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15.
  - Equivalent to AES out[r][c] = in[r][(c-r) mod 4].
  - Bytes 3, 7, 11, 15 (row 0) pass unchanged.
- Pipeline: stage i holds v[i] and d[i][127:0].
  - ready[i] = !v[i] | ready[i+1].
  - ready[STAGES] = out_ready.
  - in_ready = ready[0], combinational; this collapses bubbles.
  - Stage i loads when ready[i]. Stage 0 loads v = in_valid and d = mapped input. Stage i>0 loads v[i-1] and d[i-1].
  - When a stage is not ready, it holds its contents.
- Outputs: out_valid = v[STAGES-1]; state_isr_out = d[STAGES-1].
- Latency: with out_ready held high, a state accepted at edge N appears with out_valid at edge N+STAGES-1 registered output. That is STAGES cycles accept-to-visible.
- Throughput: one state per cycle when out_ready is held high.
- Stability: while out_valid=1 and out_ready=0, state_isr_out and out_valid must stay stable. No data may be dropped or duplicated.
- Full pipeline: when all stages are valid and out_ready=0, in_ready=0.
- Simultaneous events: accept and emit in the same cycle are both legal. A full pipe with out_ready=1 still accepts a new input (in_ready=1).
- busy = OR of all v[i].
- xfer_cnt increments on each out_valid & out_ready and wraps modulo 2^CNT_W with no saturation.
- Reset values: all v[i]=0, d[i]=0, out_valid=0, state_isr_out=0, xfer_cnt=0, err=0, busy=0.
  - in_ready=1 after reset, because it is combinational from the cleared v.
- Reset mid-operation: in-flight states are discarded. No output handshake completes in the reset cycle.
- Data registers need no reset for function but are reset for determinism.

Optional Feature:
- Macro: ISR_SELFCHECK_EN.
- Defined:
  - Each stage also carries the original pre-mapping input (shadow, 128 bits).
  - On each output transfer, the block applies forward ShiftRows to state_isr_out and compares it with the shadow. The forward map is out byte k = in byte f(k), with f = 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11, 0, 5, 10, 15.
  - Any mismatch sets err=1. err stays set until rst_n.
- Not defined: no shadow storage; err tied to 0.

Test Plan:
- Basic mapping: reset, then in=128'h0F0E0D0C0B0A09080706050403020100 with out_ready=1 → after STAGES cycles out=128'h0F0205080B0E0104070A0D000306090C, xfer_cnt=1.
- Round-trip: apply forward ShiftRows to 200 random states and feed them in → each output equals the original state, in order; err=0 with ISR_SELFCHECK_EN.
- Backpressure: stream 10 states with out_ready low for 5 cycles mid-stream → in_ready drops after STAGES accepts, outputs stay stable while stalled, no loss or duplication, xfer_cnt=10.
- Full streaming: in_valid=1 and out_ready=1 continuously for 64 cycles → 64-STAGES+1 outputs by cycle 64, in_ready never drops.
- Reset mid-flight: two states in flight, assert rst_n=0 → out_valid=0, busy=0, xfer_cnt=0 immediately (asynchronous). After release, in_ready=1 and the next state flows normally.
- Counter wrap: CNT_W=4, 17 transfers → xfer_cnt=1.

Source files
------------

// File: rtl/inv_shift_rows_pipe.sv
// ============================================================================
// Module   : inv_shift_rows_pipe
// Brief    : Pipelined AES InvShiftRows stage with valid/ready backpressure.
//            Optional macro ISR_SELFCHECK_EN adds a forward-ShiftRows check of
//            every output transfer against a shadow copy of the input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_shift_rows_pipe #(
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     state_isr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     state_isr_out,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             err
);

    // Byte k sits at bits [8k+7:8k]; byte 15 is s(0,0), column-major.
    function automatic logic [127:0] f_inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r[8*0  +: 8] = s[8*12 +: 8];
        r[8*1  +: 8] = s[8*9  +: 8];
        r[8*2  +: 8] = s[8*6  +: 8];
        r[8*3  +: 8] = s[8*3  +: 8];
        r[8*4  +: 8] = s[8*0  +: 8];
        r[8*5  +: 8] = s[8*13 +: 8];
        r[8*6  +: 8] = s[8*10 +: 8];
        r[8*7  +: 8] = s[8*7  +: 8];
        r[8*8  +: 8] = s[8*4  +: 8];
        r[8*9  +: 8] = s[8*1  +: 8];
        r[8*10 +: 8] = s[8*14 +: 8];
        r[8*11 +: 8] = s[8*11 +: 8];
        r[8*12 +: 8] = s[8*8  +: 8];
        r[8*13 +: 8] = s[8*5  +: 8];
        r[8*14 +: 8] = s[8*2  +: 8];
        r[8*15 +: 8] = s[8*15 +: 8];
        return r;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [127:0]      r_d [STAGES];
    logic [STAGES:0]   w_ready;
    logic [127:0]      w_mapped;
    logic              w_xfer;
    logic [CNT_W-1:0]  r_cnt;

    assign w_mapped = f_inv_shift_rows(state_isr_in);

    // Ready ripples back from the sink so an empty stage absorbs a bubble.
    always_comb begin
        w_ready[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_ready[i] = !r_v[i] | w_ready[i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_v[0] <= in_valid;
                r_d[0] <= w_mapped;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_v[i] <= r_v[i-1];
                    r_d[i] <= r_d[i-1];
                end
            end
        end
    end

    assign in_ready      = w_ready[0];
    assign out_valid     = r_v[STAGES-1];
    assign state_isr_out = r_d[STAGES-1];
    assign busy          = |r_v;
    assign w_xfer        = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign xfer_cnt = r_cnt;

`ifdef ISR_SELFCHECK_EN
    function automatic logic [127:0] f_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r[8*0  +: 8] = s[8*4  +: 8];
        r[8*1  +: 8] = s[8*9  +: 8];
        r[8*2  +: 8] = s[8*14 +: 8];
        r[8*3  +: 8] = s[8*3  +: 8];
        r[8*4  +: 8] = s[8*8  +: 8];
        r[8*5  +: 8] = s[8*13 +: 8];
        r[8*6  +: 8] = s[8*2  +: 8];
        r[8*7  +: 8] = s[8*7  +: 8];
        r[8*8  +: 8] = s[8*12 +: 8];
        r[8*9  +: 8] = s[8*1  +: 8];
        r[8*10 +: 8] = s[8*6  +: 8];
        r[8*11 +: 8] = s[8*11 +: 8];
        r[8*12 +: 8] = s[8*0  +: 8];
        r[8*13 +: 8] = s[8*5  +: 8];
        r[8*14 +: 8] = s[8*10 +: 8];
        r[8*15 +: 8] = s[8*15 +: 8];
        return r;
    endfunction

    logic [127:0] r_s [STAGES];
    logic         r_err;
    logic [127:0] w_fwd;

    // Shadow of the unmapped input travels in lockstep with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                r_s[i] <= '0;
            end
        end else begin
            if (w_ready[0]) begin
                r_s[0] <= state_isr_in;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_ready[i]) begin
                    r_s[i] <= r_s[i-1];
                end
            end
        end
    end

    assign w_fwd = f_shift_rows(state_isr_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_xfer && (w_fwd != r_s[STAGES-1])) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire
